// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU and its iterative multiplier.
package alu_pkg;

  localparam int OP_W      = 4;
  localparam int W_DEF     = 8;
  localparam int MUL_STEPS = W_DEF;  // one shift-add step per datapath bit

  typedef enum logic [OP_W-1:0] {
    OP_SETI   = 4'h0,
    OP_SGT    = 4'h1,
    OP_ADDI   = 4'h2,
    OP_SUBI   = 4'h3,
    OP_LOGIC  = 4'h4,
    OP_ADDR   = 4'h5,
    OP_JUMP   = 4'h6,
    OP_SEQ    = 4'h7,
    OP_BONE   = 4'h8,
    OP_BZERO  = 4'h9,
    OP_PARITY = 4'hA,
    OP_LOAD   = 4'hB,
    OP_STORE  = 4'hC,
    OP_SHI    = 4'hD,
    OP_SHR    = 4'hE,
    OP_MUL    = 4'hF
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

endpackage

// File: rtl/alu_pipe_mul.sv
// Radix-2 shift-add multiplier: the first step is taken on the start edge, so the
// full product sits in the register W-1 edges later.
module mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]   mcand, m_src;
  logic [2*W-1:0] p_src;
  logic [W:0]     sum;
  logic [CW-1:0]  cnt;

  // Upper half accumulates the multiplicand; lower half shifts the multiplier out.
  assign m_src = start ? a : mcand;
  assign p_src = start ? {{W{1'b0}}, b} : product;
  assign sum   = {1'b0, p_src[2*W-1:W]} + (p_src[0] ? {1'b0, m_src} : '0);
  // High while the final step is being taken this cycle.
  assign done  = busy && (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      cnt     <= CW'(1);
      mcand   <= a;
      product <= {sum, p_src[W-1:1]};
    end else if (busy) begin
      product <= {sum, p_src[W-1:1]};
      cnt     <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake; MUL runs iteratively and stalls the input.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int W     = MUL_STEPS,
  parameter int IMM_W = 5,
  parameter int SH_W  = $clog2(W) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             flag,
  input  logic [IMM_W-1:0] imm,
  input  logic [W-1:0]     acc_in,
  input  logic [W-1:0]     reg_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic [W-1:0]     out_hi,
  output logic             carry,
  output logic             br_comp
);

  state_t         state, state_next;
  op_t            op_e;
  logic           accept, mul_start, mul_busy, mul_done;
  logic [2*W-1:0] product;
  logic [W-1:0]   imm_ext, r_out;
  logic           r_carry, r_br;
  logic [W:0]     sum_i, sum_r;

  assign op_e      = op_t'(op);
  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e == OP_MUL);
  assign imm_ext   = W'(imm);
  assign sum_i     = {1'b0, acc_in} + {1'b0, imm_ext};
  assign sum_r     = {1'b0, acc_in} + {1'b0, reg_in};

  // Full amount is range-checked before narrowing, so large amounts flush to zero.
  function automatic logic [W-1:0] shift(input logic [W-1:0] v, input logic [W-1:0] amt,
                                         input logic right);
    if (amt >= W'(W)) return '0;
    return right ? v >> amt[SH_W-1:0] : v << amt[SH_W-1:0];
  endfunction

  always_comb begin
    r_out   = '0;
    r_carry = 1'b0;
    r_br    = 1'b0;
    case (op_e)
      OP_SETI:   r_out = imm_ext;
      OP_SGT:    r_out = W'(acc_in > reg_in);
      OP_ADDI:   {r_carry, r_out} = sum_i;
      OP_SUBI:   begin r_out = acc_in - imm_ext; r_carry = (acc_in >= imm_ext); end
      OP_LOGIC:  r_out = flag ? (acc_in ^ reg_in) : (acc_in | reg_in);
      OP_ADDR:   {r_carry, r_out} = sum_r;
      OP_JUMP:   r_br = 1'b1;
      OP_SEQ:    r_out = W'(acc_in == reg_in);
      OP_BONE:   r_br = (acc_in == W'(1));
      OP_BZERO:  r_br = (acc_in == '0);
      OP_PARITY: r_out = W'(^acc_in);
      OP_LOAD:   r_out = reg_in;
      OP_STORE:  r_out = acc_in;
      OP_SHI:    r_out = shift(acc_in, imm_ext, flag);
      OP_SHR:    r_out = shift(acc_in, reg_in, flag);
      default:   ;
    endcase
  end

  mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc_in),
    .b       (reg_in),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (mul_start) state_next = S_MUL;
      S_MUL:   if (mul_done) state_next = S_DONE;
               else if (!mul_busy) state_next = S_IDLE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output register: MUL completion, then single-cycle results, then drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_hi    <= '0;
      carry     <= 1'b0;
      br_comp   <= 1'b0;
    end else if (state == S_DONE) begin
      out_valid <= 1'b1;
      out       <= product[W-1:0];
      out_hi    <= product[2*W-1:W];
      carry     <= 1'b0;
      br_comp   <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      out       <= r_out;
      out_hi    <= '0;
      carry     <= r_carry;
      br_comp   <= r_br;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
